// File: rtl/mac_arb_pkg.sv
// Shared constants, ID-width helper and tag type for the multiply-add pipeline arbiter.
package mac_arb_pkg;

  localparam int unsigned NUM_REQ_DEF  = 4;
  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned PIPE_LAT_DEF = 3;
  // Tag IDs are sized for the largest supported requester count (16).
  localparam int unsigned MAX_ID_W     = 4;

  function automatic int unsigned id_width(input int unsigned n);
    return $clog2(n);
  endfunction

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } mac_tag_t;

endpackage

// File: rtl/mac_pipe_arbiter_rr.sv
// One-hot round-robin grant over a request vector; the pointer moves past the winner on advance.
module rr_arbiter
  import mac_arb_pkg::*;
#(
  parameter int unsigned N = NUM_REQ_DEF,
  localparam int unsigned IW = id_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          advance,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr;
  logic [IW:0]   cand;
  logic          found;

  // First valid requester at or after ptr, scanning with wrap-around.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && req[IW'(cand)]) begin
        found = 1'b1;
        idx   = IW'(cand);
      end
    end
    if (found && en && !rst) grant[idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (idx == IW'(N-1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/mac_pipe_arbiter.sv
// Round-robin issue of operand triples into a fixed-latency multiply-add pipeline with ID-tagged responses.
// Define MAC_ARB_PERF_EN to add the saturating 32-bit perf_issue_cnt handshake counter.
module mac_pipe_arbiter
  import mac_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = NUM_REQ_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned PIPE_LAT = PIPE_LAT_DEF,
  localparam int unsigned IW = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*DATA_W-1:0] req_c,
  output logic [DATA_W-1:0]         mac_a,
  output logic [DATA_W-1:0]         mac_b,
  output logic [DATA_W-1:0]         mac_c,
  input  logic [DATA_W-1:0]         mac_out,
  output logic                      rsp_valid,
  output logic [IW-1:0]             rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
`ifdef MAC_ARB_PERF_EN
  output logic                      busy,
  output logic [31:0]               perf_issue_cnt
`else
  output logic                      busy
`endif
);

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      g_idx;
  logic               handshake;
  logic [31:0]        sel;
  mac_tag_t           slot_q;
  mac_tag_t           tag_q [PIPE_LAT];

  assign req_ready = grant;
  assign handshake = |(req_valid & grant);
  assign sel       = 32'(g_idx) * DATA_W;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .advance (handshake),
    .req     (req_valid),
    .grant   (grant),
    .idx     (g_idx)
  );

  // Operand registers hold their last value when nothing is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_a <= '0;
      mac_b <= '0;
      mac_c <= '0;
    end else if (handshake) begin
      mac_a <= req_a[sel +: DATA_W];
      mac_b <= req_b[sel +: DATA_W];
      mac_c <= req_c[sel +: DATA_W];
    end
  end

  // Issue slot plus a tag shift register aligned with the pipeline stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) tag_q[i] <= '0;
    end else begin
      slot_q.valid <= handshake;
      slot_q.id    <= handshake ? MAX_ID_W'(g_idx) : '0;
      tag_q[0]     <= slot_q;
      for (int i = 1; i < PIPE_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign rsp_valid = tag_q[PIPE_LAT-1].valid;
  assign rsp_id    = IW'(tag_q[PIPE_LAT-1].id);
  assign rsp_data  = mac_out;

  always_comb begin
    busy = slot_q.valid;
    for (int i = 0; i < PIPE_LAT; i++) busy = busy | tag_q[i].valid;
  end

`ifdef MAC_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issue_cnt <= '0;
    end else if (handshake && (perf_issue_cnt != '1)) begin
      perf_issue_cnt <= perf_issue_cnt + 32'd1;
    end
  end
`endif

endmodule
